// File: rtl/inst_fetch_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_pkg
//   Shared definitions for the instruction fetch stage: reset level, common
//   word constants, bus widths, the fetch FSM state encoding and a small pc
//   alignment helper.
//
//   Optional feature macro used by the fetch stage: INST_FETCH_ALIGN_CHECK_EN
// -----------------------------------------------------------------------------
package inst_fetch_pkg;

    // Reset level and common constants
    localparam logic        RstEnable   = 1'b1;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    // Bus widths
    localparam int          InstAddrBus = 32;
    localparam int          InstBus     = 32;

    // Fetch FSM state encoding
    localparam logic [1:0]  IDLE        = 2'd0;
    localparam logic [1:0]  REQ         = 2'd1;
    localparam logic [1:0]  HOLD        = 2'd2;

    // Clears the byte-offset bits so a pc always names a whole word.
    function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] addr);
        return {addr[InstAddrBus-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
//   Program counter register with its next-pc mux. Priority: reset, branch
//   redirect, sequential advance, hold. Arithmetic is plain 32-bit modulo, so
//   0xFFFF_FFFC + 4 wraps to 0 with no flag.
//   Without INST_FETCH_ALIGN_CHECK_EN every value loaded into the pc has its
//   low two bits forced to zero; with it, misaligned targets are kept so the
//   fetch stage can raise an address exception.
//
// Ports
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   branch  : load target this cycle
//   target  : redirect address
//   advance : step pc by PC_STEP this cycle
//   pc      : current fetch address
// -----------------------------------------------------------------------------
module pc_reg
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] PC_STEP      = 32'd4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   branch,
    input  logic [InstAddrBus-1:0] target,
    input  logic                   advance,
    output logic [InstAddrBus-1:0] pc
);

    logic [InstAddrBus-1:0] pc_val_reg;
    logic [InstAddrBus-1:0] pc_mux;
    logic [InstAddrBus-1:0] pc_next;
    logic [InstAddrBus-1:0] reset_value;

    always_comb begin
        pc_mux = pc_val_reg;
        if (branch) begin
            pc_mux = target;
        end else if (advance) begin
            pc_mux = pc_val_reg + PC_STEP;
        end
    end

`ifdef INST_FETCH_ALIGN_CHECK_EN
    assign pc_next     = pc_mux;
    assign reset_value = RESET_VECTOR;
`else
    assign pc_next     = word_align(pc_mux);
    assign reset_value = word_align(RESET_VECTOR);
`endif

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            pc_val_reg <= reset_value;
        end else begin
            pc_val_reg <= pc_next;
        end
    end

    assign pc = pc_val_reg;

endmodule

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//   Instruction fetch stage. Issues one memory request per cycle while in REQ
//   (zero-wait memory gives one instruction per cycle), buffers a returned
//   word in HOLD when downstream stalls, and redirects on a decode branch.
//   Branch beats stall and beats a same-cycle rom_ack (that word is dropped).
//
//   Optional feature: INST_FETCH_ALIGN_CHECK_EN adds if_excp_adel. A
//   misaligned pc in REQ is then presented as an exception (if_inst = 0,
//   if_valid = 1, if_excp_adel = 1) and the stage parks in HOLD until the
//   next branch.
//
// Ports
//   clk, rst         : clock (rising edge), synchronous active-high reset
//   stall_i          : downstream cannot accept an instruction this cycle
//   branch_flag_i    : redirect request from decode
//   branch_target_i  : redirect address
//   rom_ce, rom_addr : instruction memory request (decoded from state and pc)
//   rom_ack, rom_data: memory response, may arrive in the request cycle
//   if_pc, if_inst   : presented instruction and its address (registered)
//   if_valid         : if_pc/if_inst hold a real instruction (registered)
//   if_excp_adel     : address-error exception (only with the macro)
// -----------------------------------------------------------------------------
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] PC_STEP      = 32'd4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   branch_flag_i,
    input  logic [InstAddrBus-1:0] branch_target_i,
    output logic                   rom_ce,
    output logic [InstAddrBus-1:0] rom_addr,
    input  logic                   rom_ack,
    input  logic [InstBus-1:0]     rom_data,
    output logic [InstAddrBus-1:0] if_pc,
    output logic [InstBus-1:0]     if_inst,
`ifdef INST_FETCH_ALIGN_CHECK_EN
    output logic                   if_excp_adel,
`endif
    output logic                   if_valid
);

    logic [1:0]             state_reg;
    logic [InstAddrBus-1:0] pc;
    logic [InstAddrBus-1:0] if_pc_reg;
    logic [InstBus-1:0]     if_inst_reg;
    logic                   if_valid_reg;
    logic [InstAddrBus-1:0] buf_pc_reg;
    logic [InstBus-1:0]     buf_inst_reg;
    logic                   adel_reg;
    logic                   misaligned;
    logic                   in_req;
    logic                   advance;

`ifdef INST_FETCH_ALIGN_CHECK_EN
    assign misaligned = (pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign in_req = (state_reg == REQ);

    // A request is only live in REQ with an aligned pc; reset kills it
    // immediately so nothing is issued while rst is high.
    assign rom_ce   = (rst != RstEnable) && in_req && !misaligned;
    assign rom_addr = pc;

    // pc steps whenever a live request is acknowledged and not overridden
    // by reset or a branch (stalled acks still advance; the word is buffered).
    assign advance = (rst != RstEnable) && !branch_flag_i && in_req
                   && !misaligned && rom_ack;

    pc_reg #(
        .RESET_VECTOR (RESET_VECTOR),
        .PC_STEP      (PC_STEP)
    ) u_pc_reg (
        .clk     (clk),
        .rst     (rst),
        .branch  (branch_flag_i),
        .target  (branch_target_i),
        .advance (advance),
        .pc      (pc)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_reg    <= IDLE;
            if_pc_reg    <= ZeroWord;
            if_inst_reg  <= ZeroWord;
            if_valid_reg <= 1'b0;
            buf_pc_reg   <= ZeroWord;
            buf_inst_reg <= ZeroWord;
            adel_reg     <= 1'b0;
        end else if (branch_flag_i) begin
            // Redirect: drop any buffered word and any pending exception.
            state_reg    <= REQ;
            if_valid_reg <= 1'b0;
            buf_pc_reg   <= ZeroWord;
            buf_inst_reg <= ZeroWord;
            adel_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg <= REQ;
                end
                REQ: begin
                    if (misaligned) begin
                        if_pc_reg    <= pc;
                        if_inst_reg  <= ZeroWord;
                        if_valid_reg <= 1'b1;
                        adel_reg     <= 1'b1;
                        state_reg    <= HOLD;
                    end else if (rom_ack) begin
                        if (!stall_i) begin
                            if_pc_reg    <= pc;
                            if_inst_reg  <= rom_data;
                            if_valid_reg <= 1'b1;
                        end else begin
                            buf_pc_reg   <= pc;
                            buf_inst_reg <= rom_data;
                            state_reg    <= HOLD;
                        end
                    end else if (!stall_i) begin
                        if_valid_reg <= 1'b0;
                    end
                end
                HOLD: begin
                    // An exception parks here until a branch arrives.
                    if (!adel_reg && !stall_i) begin
                        if_pc_reg    <= buf_pc_reg;
                        if_inst_reg  <= buf_inst_reg;
                        if_valid_reg <= 1'b1;
                        state_reg    <= REQ;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign if_pc    = if_pc_reg;
    assign if_inst  = if_inst_reg;
    assign if_valid = if_valid_reg;

`ifdef INST_FETCH_ALIGN_CHECK_EN
    assign if_excp_adel = adel_reg;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//   Directed bench for inst_fetch. The memory returns {16'hC0DE, addr[15:0]}
//   so each presented word identifies the address it came from.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic        rom_ack;
    logic [31:0] rom_data;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
`ifdef INST_FETCH_ALIGN_CHECK_EN
    logic        if_excp_adel;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    assign rom_data = {16'hC0DE, rom_addr[15:0]};

    inst_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .rom_ce          (rom_ce),
        .rom_addr        (rom_addr),
        .rom_ack         (rom_ack),
        .rom_data        (rom_data),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
`ifdef INST_FETCH_ALIGN_CHECK_EN
        .if_excp_adel    (if_excp_adel),
`endif
        .if_valid        (if_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0;
        branch_target_i = 32'h0; rom_ack = 1'b0;

        // ---- reset state
        step(); step();
        check("rst_rom_ce",   {31'd0, rom_ce},   32'd0);
        check("rst_rom_addr", rom_addr,          32'h0);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_if_pc",    if_pc,             32'h0);
        check("rst_if_inst",  if_inst,           32'h0);

        // ---- zero-wait streaming: 0x0, 0x4, 0x8
        rst = 1'b0; rom_ack = 1'b1;
        step();
        check("idle2req_rom_ce", {31'd0, rom_ce}, 32'd1);
        check("seq_addr0",       rom_addr,        32'h0);
        check("seq_valid0",      {31'd0, if_valid}, 32'd0);
        step();
        check("seq_addr4",  rom_addr,          32'h4);
        check("seq_pc0",    if_pc,             32'h0);
        check("seq_inst0",  if_inst,           32'hC0DE_0000);
        check("seq_valid1", {31'd0, if_valid}, 32'd1);
        step();
        check("seq_addr8",  rom_addr, 32'h8);
        check("seq_pc4",    if_pc,    32'h4);

        // ---- ack delayed 3 cycles at 0x8
        rom_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("wait_addr8",  rom_addr,          32'h8);
            check("wait_valid0", {31'd0, if_valid}, 32'd0);
        end
        rom_ack = 1'b1;
        step();
        check("wait_pc8",    if_pc,             32'h8);
        check("wait_inst8",  if_inst,           32'hC0DE_0008);
        check("wait_valid1", {31'd0, if_valid}, 32'd1);
        check("wait_addrC",  rom_addr,          32'hC);

        // ---- branch to 0x100 coinciding with ack of 0xC
        branch_flag_i = 1'b1; branch_target_i = 32'h100;
        step();
        branch_flag_i = 1'b0;
        check("br_valid0",  {31'd0, if_valid}, 32'd0);
        check("br_pc_keep", if_pc,             32'h8);
        check("br_addr",    rom_addr,          32'h100);
        check("br_rom_ce",  {31'd0, rom_ce},   32'd1);
        step();
        check("br_pc100",   if_pc,    32'h100);
        check("br_inst100", if_inst,  32'hC0DE_0100);
        check("br_addr104", rom_addr, 32'h104);

        // ---- wrap at top of address space
        branch_flag_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
        step();
        branch_flag_i = 1'b0;
        check("wrap_addr_top", rom_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_pc_top",   if_pc,    32'hFFFF_FFFC);
        check("wrap_addr0",    rom_addr, 32'h0);

        // ---- REQ without ack while stalled holds outputs
        rom_ack = 1'b0; stall_i = 1'b1;
        step();
        check("reqstall_valid", {31'd0, if_valid}, 32'd1);
        check("reqstall_pc",    if_pc,             32'hFFFF_FFFC);
        stall_i = 1'b0;
        step();
        check("reqnoack_valid0", {31'd0, if_valid}, 32'd0);

        // ---- reset mid-fetch: rom_ce drops while rst high, late ack ignored
        rst = 1'b1;
        #1;
        check("rstmid_rom_ce", {31'd0, rom_ce}, 32'd0);
        step();
        rst = 1'b0; rom_ack = 1'b1;
        step();
        check("rstmid_valid0", {31'd0, if_valid}, 32'd0);
        check("rstmid_pc0",    if_pc,             32'h0);
        check("rstmid_addr0",  rom_addr,          32'h0);

        // ---- stall 2 cycles during ack of 0x4
        step();
        check("st_pc0",   if_pc,    32'h0);
        check("st_addr4", rom_addr, 32'h4);
        stall_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("st_hold_pc",    if_pc,             32'h0);
            check("st_hold_valid", {31'd0, if_valid}, 32'd1);
            check("st_hold_ce",    {31'd0, rom_ce},   32'd0);
        end
        stall_i = 1'b0;
        step();
        check("st_pc4",    if_pc,             32'h4);
        check("st_inst4",  if_inst,           32'hC0DE_0004);
        check("st_valid",  {31'd0, if_valid}, 32'd1);
        check("st_addr8",  rom_addr,          32'h8);
        step();
        check("st_pc8",    if_pc,    32'h8);
        check("st_inst8",  if_inst,  32'hC0DE_0008);

        // ---- misaligned branch target
        branch_flag_i = 1'b1; branch_target_i = 32'h102;
        step();
        branch_flag_i = 1'b0;
`ifdef INST_FETCH_ALIGN_CHECK_EN
        check("adel_ce0", {31'd0, rom_ce}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("adel_flag",  {31'd0, if_excp_adel}, 32'd1);
            check("adel_pc",    if_pc,                 32'h102);
            check("adel_inst",  if_inst,               32'h0);
            check("adel_valid", {31'd0, if_valid},     32'd1);
            check("adel_ce",    {31'd0, rom_ce},       32'd0);
        end
        branch_flag_i = 1'b1; branch_target_i = 32'h200;
        step();
        branch_flag_i = 1'b0;
        check("adel_clr",  {31'd0, if_excp_adel}, 32'd0);
        check("adel_addr", rom_addr,              32'h200);
`else
        check("align_addr100", rom_addr,        32'h100);
        check("align_ce",      {31'd0, rom_ce}, 32'd1);
        step();
        check("align_pc100",   if_pc,   32'h100);
        check("align_inst100", if_inst, 32'hC0DE_0100);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_VECTOR, 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter PC_STEP, 4: byte increment between sequential fetches.
REQ-003 Port clk  input  1: sole clock, rising edge.
REQ-004 Port rst  input  1: reset; one clock; reset is synchronous and active-high.
REQ-005 Port stall_i  input  1: downstream cannot accept a new instruction this cycle.
REQ-006 Port branch_flag_i  input  1: redirect request from decode.
REQ-007 Port branch_target_i  input  32: redirect address.
REQ-008 Port rom_ce  output  1: instruction memory request valid.
REQ-009 Port rom_addr  output  32: instruction memory byte address.
REQ-010 Port rom_ack  input  1: memory returns rom_data this cycle; zero-wait allowed.
REQ-011 Port rom_data  input  32: instruction word.
REQ-012 Port if_pc  output  32: address of the presented instruction, to IF/ID.
REQ-013 Port if_inst  output  32: presented instruction, to IF/ID.
REQ-014 Port if_valid  output  1: if_pc/if_inst hold a real instruction.

Function
REQ-015 The block SHALL implement states IDLE, REQ, HOLD; all outputs SHALL be registered except rom_ce/rom_addr, which SHALL decode from state and pc.
REQ-016 IDLE SHALL drive rom_ce=0 and SHALL move to REQ the cycle after rst deasserts.
REQ-017 REQ SHALL drive rom_ce=1, rom_addr=pc, and stay in REQ until rom_ack.
REQ-018 On rom_ack in REQ with stall_i=0, the block SHALL load if_pc=pc, if_inst=rom_data, if_valid=1, set pc=pc+PC_STEP, and remain in REQ (one instruction per cycle at zero-wait).
REQ-019 On rom_ack in REQ with stall_i=1, the block SHALL hold if_pc/if_inst/if_valid unchanged, buffer rom_data and pc internally, set pc=pc+PC_STEP, and enter HOLD.
REQ-020 HOLD SHALL drive rom_ce=0; on stall_i=0 it SHALL present the buffered word with if_valid=1 and return to REQ.
REQ-021 In REQ without rom_ack, if_valid SHALL clear to 0 unless stall_i=1, in which case outputs SHALL hold.
REQ-022 branch_flag_i=1 in any state SHALL set pc=branch_target_i, clear if_valid to 0 next cycle, drop any HOLD buffer, and enter REQ; branch SHALL take priority over stall_i and over a same-cycle rom_ack.
REQ-023 A rom_ack coinciding with branch_flag_i SHALL be discarded; the first fetch after the branch SHALL issue at branch_target_i the next cycle.
REQ-024 pc arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 SHALL wrap to 32'h0000_0000 without flags.

Reset
REQ-025 With rst=1 at a clock edge: state=IDLE, pc=RESET_VECTOR, if_pc=0, if_inst=0, if_valid=0, HOLD buffer cleared; rom_ce=0 while rst is high.
REQ-026 Reset asserted mid-fetch SHALL abandon the outstanding request; a late rom_ack SHALL be ignored until state REQ is re-entered.

Configuration
REQ-027 Macro INST_FETCH_ALIGN_CHECK_EN: when defined, output if_excp_adel (1 bit) SHALL be added; a pc with bits[1:0]!=0 in REQ SHALL suppress rom_ce, present if_pc=pc, if_inst=0, if_valid=1, if_excp_adel=1, and stall in HOLD until branch_flag_i.
REQ-028 Without the macro, no port is added and pc[1:0] SHALL be forced to 2'b00 on load.

Structure
REQ-029 RstEnable, ZeroWord, InstAddrBus, InstBus widths and the state encoding SHALL live in the shared defines package.
REQ-030 The block SHALL be one module; the pc register with next-pc mux MAY be a sub-module named pc_reg.

Verification
REQ-031 Reset release, rom_ack tied 1 -> rom_addr 0x0,0x4,0x8 on consecutive cycles; if_pc follows one cycle later with if_valid=1.
REQ-032 rom_ack delayed 3 cycles at 0x8 -> rom_addr holds 0x8, if_valid=0 for 3 cycles, then if_pc=0x8.
REQ-033 stall_i=1 for 2 cycles during ack of 0x4 -> if_pc holds 0x0, rom_ce=0, then if_pc=0x4 with no lost or duplicated word.
REQ-034 branch_flag_i=1, target 0x100, same cycle as rom_ack of 0xC -> word for 0xC never presented; next rom_addr=0x100.
REQ-035 pc preset near top via branch to 0xFFFF_FFFC -> following rom_addr=0x0000_0000.
REQ-036 With INST_FETCH_ALIGN_CHECK_EN, branch to 0x102 -> rom_ce=0, if_excp_adel=1, if_pc=0x102 until next branch.
